stack_ctrl: RTL and testbench
=============================

# stack_ctrl

Evaluation-stack controller for the CPU datapath: keeps top-of-stack (TOS) in a register and spills deeper entries into the `stack` RAM (async read, sync write) that sits directly downstream of it. It decodes one stack operation per clock, drives the RAM's read/write ports and tracks depth. It also presents TOS/NOS to the ALU and flags overflow/underflow.

## Interface
- ADDR_WIDTH, 4, address width of the attached stack RAM (RAM holds 2**ADDR_WIDTH entries)
- DATA_WIDTH, 16, stack word width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- op  in  3  operation: 000 NOP, 001 PUSH, 010 POP, 011 REPLACE, 100 POP_REPLACE, 101 SWAP, 110/111 treated as NOP
- din  in  DATA_WIDTH  value for PUSH / REPLACE / POP_REPLACE
- clear_err  in  1  clears sticky error flags
- tos  out  DATA_WIDTH  top of stack (registered)
- nos  out  DATA_WIDTH  next on stack = ram_rd_data when depth>=2, else 0
- depth  out  ADDR_WIDTH+1  number of valid entries, 0..2**ADDR_WIDTH+1
- empty  out  1  depth==0
- full  out  1  depth==2**ADDR_WIDTH+1
- overflow  out  1  sticky: PUSH attempted while full
- underflow  out  1  sticky: op attempted with too few entries
- ram_rd_addr  out  ADDR_WIDTH  to RAM rd_addr
- ram_wr_addr  out  ADDR_WIDTH  to RAM wr_addr
- ram_wr_enable  out  1  to RAM wr_enable
- ram_wr_data  out  DATA_WIDTH  to RAM wr_data
- ram_rd_data  in  DATA_WIDTH  from RAM rd_data (combinational)

## Operation
- Storage: TOS register + RAM. RAM entries in use = depth-1 (depth>=1); sp = depth-1 is the next free RAM slot; NOS lives at sp-1.
- ram_rd_addr = sp-1 (mod 2**ADDR_WIDTH) always; content ignored when depth<2.
- PUSH (needs depth<full): ram[sp] <= tos (if depth>=1), tos <= din, depth+1. When depth==0 no RAM write.
- POP (needs depth>=1): tos <= nos (0 if depth==1), depth-1. No RAM write.
- REPLACE (needs depth>=1): tos <= din, depth unchanged.
- POP_REPLACE (binary-op result; needs depth>=2): tos <= din, depth-1.
- SWAP (needs depth>=2): tos <= nos, ram[sp-1] <= tos; depth unchanged. Write and async read target the same address in the same cycle; read returns pre-edge value.
- Precondition failure: no state change, no RAM write, set overflow (PUSH when full) or underflow (all other ops).
- Error flags sticky until reset or clear_err. clear_err and a new error in the same cycle: flag set (error wins).
- Reserved ops 110/111: NOP, no flag.
- ram_wr_enable asserted only for legal PUSH with depth>=1 or legal SWAP; forced 0 while reset is high.
- Depth arithmetic in ADDR_WIDTH+1 bits, never wraps (guarded by preconditions).

## Timing
- Single-cycle: op/din sampled at rising edge; tos, depth, flags valid after that edge. No handshake; one op accepted every cycle.
- ram_wr_* are combinational from op, depth, tos in the same cycle; RAM commits at the same edge.
- nos, empty, full are combinational from registered state and ram_rd_data.
- Reset (synchronous, wins over any op): tos=0, depth=0, overflow=0, underflow=0, empty=1, full=0, nos=0, ram_wr_enable=0. RAM contents not cleared. Reset mid-sequence discards stack.

## Test plan
- Reset then PUSH 0x1111, 0x2222, 0x3333 -> depth=3, tos=0x3333, nos=0x2222; RAM[0]=0x1111, RAM[1]=0x2222; empty=0.
- From that state POP x3 -> tos 0x2222, 0x1111, 0x0000; depth 2,1,0; empty=1, underflow=0; a 4th POP -> underflow=1, depth stays 0.
- Push 17 values (AW=4) -> full=1, depth=17; 18th PUSH -> overflow=1, tos and RAM unchanged, ram_wr_enable=0 that cycle; clear_err -> overflow=0.
- Stack [5,7] (tos=7): SWAP -> tos=5, nos=7; POP_REPLACE din=12 -> tos=12, depth=1; SWAP at depth 1 -> underflow=1, tos=12.
- REPLACE din=0xABCD at depth 0 -> underflow=1, tos=0; same cycle clear_err=1 with failing op -> underflow remains 1.
- Assert reset while issuing PUSH at depth 5 -> next cycle depth=0, tos=0, flags 0, no RAM write; op 111 -> no state change, no flag.

Source files
------------

// File: rtl/stack_ctrl.sv
// stack_ctrl -- evaluation-stack controller.
//
// Keeps the top of stack in a register and spills deeper entries into an
// external stack RAM (async read, sync write). One operation is decoded per
// clock; depth is tracked here and sticky overflow/underflow flags are raised
// when an operation's precondition fails (the operation is then dropped).
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   op, din        operation code and its data operand
//   clear_err      clears the sticky error flags
//   tos, nos       top / next-on-stack presented to the ALU
//   depth          valid entries, 0 .. 2**ADDR_WIDTH+1
//   empty, full    depth status
//   overflow       sticky: PUSH while full
//   underflow      sticky: any other op with too few entries
//   ram_rd_addr    RAM read address (always sp-1)
//   ram_wr_*       RAM write port, combinational from op/depth/tos
//   ram_rd_data    RAM async read data
module stack_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] tos,
  output logic [DATA_WIDTH-1:0] nos,
  output logic [ADDR_WIDTH:0]   depth,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_wr_enable,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam logic [2:0] OP_NOP         = 3'b000;
  localparam logic [2:0] OP_PUSH        = 3'b001;
  localparam logic [2:0] OP_POP         = 3'b010;
  localparam logic [2:0] OP_REPLACE     = 3'b011;
  localparam logic [2:0] OP_POP_REPLACE = 3'b100;
  localparam logic [2:0] OP_SWAP        = 3'b101;

  localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;
  localparam logic [ADDR_WIDTH:0]   ONE_D = 1;
  // Register + 2**ADDR_WIDTH RAM slots.
  localparam logic [ADDR_WIDTH:0]   MAX_DEPTH =
    {1'b1, {(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] sp;
  logic                  two_plus;
  logic [DATA_WIDTH-1:0] tos_next;
  logic [ADDR_WIDTH:0]   depth_next;
  logic                  ovf_set;
  logic                  unf_set;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;

  // sp is the next free RAM slot; at depth 0 it wraps, but nothing reads or
  // writes through it there because every RAM-touching op needs depth>=1.
  assign sp          = depth[ADDR_WIDTH-1:0] - ONE_A;
  assign two_plus    = (depth > ONE_D);
  assign empty       = (depth == '0);
  assign full        = (depth == MAX_DEPTH);
  assign nos         = two_plus ? ram_rd_data : '0;
  assign ram_rd_addr = sp - ONE_A;
  assign ram_wr_addr = wr_addr;
  assign ram_wr_data = tos;
  // The RAM commits on the same edge as reset, so the write must be gated.
  assign ram_wr_enable = wr_req & ~reset;

  // NOTE: every output of this block is given a default before the case so
  // that no path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    tos_next   = tos;
    depth_next = depth;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    wr_req     = 1'b0;
    wr_addr    = sp;
    case (op)
      OP_PUSH: begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          tos_next   = din;
          depth_next = depth + ONE_D;
          wr_req     = ~empty;  // first push only fills the register
        end
      end
      OP_POP: begin
        if (empty) begin
          unf_set = 1'b1;
        end else begin
          tos_next   = nos;     // nos is already 0 at depth 1
          depth_next = depth - ONE_D;
        end
      end
      OP_REPLACE: begin
        if (empty) unf_set  = 1'b1;
        else       tos_next = din;
      end
      OP_POP_REPLACE: begin
        if (!two_plus) begin
          unf_set = 1'b1;
        end else begin
          tos_next   = din;
          depth_next = depth - ONE_D;
        end
      end
      OP_SWAP: begin
        if (!two_plus) begin
          unf_set = 1'b1;
        end else begin
          // Write lands on the slot being read; the async read still returns
          // the pre-edge NOS, so the exchange completes in one cycle.
          tos_next = nos;
          wr_req   = 1'b1;
          wr_addr  = sp - ONE_A;
        end
      end
      default: ;  // NOP and reserved codes
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  // The stack RAM is deliberately not cleared on reset: depth=0 already
  // marks every slot invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      tos       <= '0;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      tos       <= tos_next;
      depth     <= depth_next;
      // A new error outranks a simultaneous clear.
      overflow  <= ovf_set | (overflow  & ~clear_err);
      underflow <= unf_set | (underflow & ~clear_err);
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Testbench for stack_ctrl: models the attached stack RAM, keeps an
// independent queue-based reference stack and compares the DUT against
// expectations pushed to a scoreboard queue at drive time.
module tb_stack_ctrl;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int MAXD = (1 << AW) + 1;

  logic          clk;
  logic          reset;
  logic [2:0]    op;
  logic [DW-1:0] din;
  logic          clear_err;
  logic [DW-1:0] tos, nos;
  logic [AW:0]   depth;
  logic          empty, full, overflow, underflow;
  logic [AW-1:0] ram_rd_addr, ram_wr_addr;
  logic          ram_wr_enable;
  logic [DW-1:0] ram_wr_data, ram_rd_data;

  int checks   = 0;
  int failures = 0;

  stack_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .op(op), .din(din), .clear_err(clear_err),
    .tos(tos), .nos(nos), .depth(depth), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow),
    .ram_rd_addr(ram_rd_addr), .ram_wr_addr(ram_wr_addr),
    .ram_wr_enable(ram_wr_enable), .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream stack RAM: async read, sync write.
  logic [DW-1:0] ram [1<<AW];
  initial for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
  always @(posedge clk) if (ram_wr_enable) ram[ram_wr_addr] <= ram_wr_data;
  assign ram_rd_data = ram[ram_rd_addr];

  // Reference model: whole stack in a queue, index size-1 is TOS.
  logic [DW-1:0] mstk[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  typedef struct {
    logic [DW-1:0] tos;
    logic [DW-1:0] nos;
    int            depth;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          unf;
  } exp_t;

  exp_t exp_q[$];

  task automatic model_step(input logic [2:0] o, input logic [DW-1:0] d,
                            input logic clr, input logic rst,
                            output logic wr, output logic [AW-1:0] wa,
                            output logic [DW-1:0] wd);
    int n = mstk.size();
    logic eo = 1'b0;
    logic eu = 1'b0;
    logic [DW-1:0] t;
    wr = 1'b0;
    wa = '0;
    wd = (n > 0) ? mstk[n-1] : '0;
    if (rst) begin
      mstk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    case (o)
      3'd1: if (n == MAXD) eo = 1'b1;
            else begin
              if (n >= 1) begin wr = 1'b1; wa = AW'(n - 1); end
              mstk.push_back(d);
            end
      3'd2: if (n == 0) eu = 1'b1; else void'(mstk.pop_back());
      3'd3: if (n == 0) eu = 1'b1; else mstk[n-1] = d;
      3'd4: if (n < 2) eu = 1'b1;
            else begin void'(mstk.pop_back()); mstk[n-2] = d; end
      3'd5: if (n < 2) eu = 1'b1;
            else begin
              wr = 1'b1; wa = AW'(n - 2);
              t = mstk[n-1]; mstk[n-1] = mstk[n-2]; mstk[n-2] = t;
            end
      default: ;
    endcase
    m_ovf = eo | (m_ovf & ~clr);
    m_unf = eu | (m_unf & ~clr);
  endtask

  function automatic exp_t model_state();
    exp_t e;
    int n = mstk.size();
    e.tos   = (n > 0) ? mstk[n-1] : '0;
    e.nos   = (n > 1) ? mstk[n-2] : '0;
    e.depth = n;
    e.empty = (n == 0);
    e.full  = (n == MAXD);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    return e;
  endfunction

  // Drive one cycle, check the combinational write port before the edge,
  // then compare registered results against the scoreboard after it.
  task automatic do_op(input logic [2:0] o, input logic [DW-1:0] d,
                       input logic clr, input logic rst);
    logic          ewr;
    logic [AW-1:0] ewa;
    logic [DW-1:0] ewd;
    exp_t          e;
    @(negedge clk);
    op = o; din = d; clear_err = clr; reset = rst;
    model_step(o, d, clr, rst, ewr, ewa, ewd);
    exp_q.push_back(model_state());
    #1;
    checks++;
    if (ram_wr_enable !== ewr) begin
      failures++;
      $display("FAIL wr_enable op=%0d: got %b want %b", o, ram_wr_enable, ewr);
    end
    if (ewr) begin
      checks++;
      if (ram_wr_addr !== ewa || ram_wr_data !== ewd) begin
        failures++;
        $display("FAIL wr_port op=%0d: got %h/%h want %h/%h",
                 o, ram_wr_addr, ram_wr_data, ewa, ewd);
      end
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (tos !== e.tos || nos !== e.nos || depth !== (AW+1)'(e.depth) ||
        empty !== e.empty || full !== e.full ||
        overflow !== e.ovf || underflow !== e.unf) begin
      failures++;
      $display("FAIL state op=%0d: got tos=%h nos=%h d=%0d e=%b f=%b o=%b u=%b want tos=%h nos=%h d=%0d e=%b f=%b o=%b u=%b",
               o, tos, nos, depth, empty, full, overflow, underflow,
               e.tos, e.nos, e.depth, e.empty, e.full, e.ovf, e.unf);
    end
  endtask

  task automatic test_reset();
    do_op(3'd1, 16'hDEAD, 1'b0, 1'b1);
    do_op(3'd0, 16'h0000, 1'b0, 1'b1);
    checks++;
    if (tos !== '0 || depth !== '0 || empty !== 1'b1 || full !== 1'b0 ||
        nos !== '0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: tos=%h depth=%0d empty=%b", tos, depth, empty);
    end
  endtask

  task automatic test_push_pop();
    do_op(3'd1, 16'h1111, 1'b0, 1'b0);
    do_op(3'd1, 16'h2222, 1'b0, 1'b0);
    do_op(3'd1, 16'h3333, 1'b0, 1'b0);
    checks++;
    if (depth !== 5'd3 || tos !== 16'h3333 || nos !== 16'h2222 ||
        ram[0] !== 16'h1111 || ram[1] !== 16'h2222 || empty !== 1'b0) begin
      failures++;
      $display("FAIL push3: depth=%0d tos=%h nos=%h ram0=%h ram1=%h want 3/3333/2222/1111/2222",
               depth, tos, nos, ram[0], ram[1]);
    end
    do_op(3'd2, '0, 1'b0, 1'b0);
    do_op(3'd2, '0, 1'b0, 1'b0);
    do_op(3'd2, '0, 1'b0, 1'b0);
    checks++;
    if (tos !== '0 || empty !== 1'b1 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL pop3: tos=%h empty=%b underflow=%b want 0/1/0", tos, empty, underflow);
    end
    do_op(3'd2, '0, 1'b0, 1'b0);
    checks++;
    if (underflow !== 1'b1 || depth !== '0) begin
      failures++;
      $display("FAIL pop_empty: underflow=%b depth=%0d want 1/0", underflow, depth);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] snap [1<<AW];
    logic [DW-1:0] t0;
    do_op(3'd0, '0, 1'b0, 1'b1);
    for (int i = 0; i < MAXD; i++) do_op(3'd1, DW'(16'h0A00 + i), 1'b0, 1'b0);
    checks++;
    if (full !== 1'b1 || depth !== 5'd17) begin
      failures++;
      $display("FAIL fill: full=%b depth=%0d want 1/17", full, depth);
    end
    for (int i = 0; i < (1 << AW); i++) snap[i] = ram[i];
    t0 = tos;
    do_op(3'd1, 16'hFFFF, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1 || tos !== t0) begin
      failures++;
      $display("FAIL overflow: overflow=%b tos=%h want 1/%h", overflow, tos, t0);
    end
    for (int i = 0; i < (1 << AW); i++) begin
      checks++;
      if (ram[i] !== snap[i] || ram[i] !== DW'(16'h0A00 + i)) begin
        failures++;
        $display("FAIL ovf_ram[%0d]: got %h want %h", i, ram[i], DW'(16'h0A00 + i));
      end
    end
    do_op(3'd0, '0, 1'b1, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL clear_ovf: overflow=%b want 0", overflow);
    end
  endtask

  task automatic test_swap();
    do_op(3'd0, '0, 1'b0, 1'b1);
    do_op(3'd1, 16'd5, 1'b0, 1'b0);
    do_op(3'd1, 16'd7, 1'b0, 1'b0);
    do_op(3'd5, '0, 1'b0, 1'b0);
    checks++;
    if (tos !== 16'd5 || nos !== 16'd7) begin
      failures++;
      $display("FAIL swap: tos=%0d nos=%0d want 5/7", tos, nos);
    end
    do_op(3'd4, 16'd12, 1'b0, 1'b0);
    checks++;
    if (tos !== 16'd12 || depth !== 5'd1) begin
      failures++;
      $display("FAIL pop_replace: tos=%0d depth=%0d want 12/1", tos, depth);
    end
    do_op(3'd5, '0, 1'b0, 1'b0);
    checks++;
    if (underflow !== 1'b1 || tos !== 16'd12) begin
      failures++;
      $display("FAIL swap_d1: underflow=%b tos=%0d want 1/12", underflow, tos);
    end
  endtask

  task automatic test_replace_empty();
    do_op(3'd0, '0, 1'b0, 1'b1);
    do_op(3'd3, 16'hABCD, 1'b0, 1'b0);
    checks++;
    if (underflow !== 1'b1 || tos !== '0) begin
      failures++;
      $display("FAIL replace_empty: underflow=%b tos=%h want 1/0", underflow, tos);
    end
    do_op(3'd3, 16'hABCD, 1'b1, 1'b0);
    checks++;
    if (underflow !== 1'b1) begin
      failures++;
      $display("FAIL err_beats_clear: underflow=%b want 1", underflow);
    end
    do_op(3'd0, '0, 1'b1, 1'b0);
    checks++;
    if (underflow !== 1'b0) begin
      failures++;
      $display("FAIL clear_unf: underflow=%b want 0", underflow);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] r4;
    for (int i = 0; i < 5; i++) do_op(3'd1, DW'(16'h5000 + i), 1'b0, 1'b0);
    do_op(3'd2, '0, 1'b0, 1'b0);
    do_op(3'd1, 16'h5004, 1'b0, 1'b0);
    do_op(3'd3, '0, 1'b0, 1'b0);
    r4 = ram[4];
    do_op(3'd1, 16'h7777, 1'b0, 1'b1);
    checks++;
    if (depth !== '0 || tos !== '0 || overflow !== 1'b0 ||
        underflow !== 1'b0 || ram[4] !== r4) begin
      failures++;
      $display("FAIL reset_mid: depth=%0d tos=%h ram4=%h want 0/0/%h", depth, tos, ram[4], r4);
    end
    do_op(3'd1, 16'h0042, 1'b0, 1'b0);
    do_op(3'd7, 16'h9999, 1'b0, 1'b0);
    do_op(3'd6, 16'h9999, 1'b0, 1'b0);
    checks++;
    if (tos !== 16'h0042 || depth !== 5'd1 || underflow !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reserved_op: tos=%h depth=%0d want 0042/1 no flags", tos, depth);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] o;
    for (int i = 0; i < 400; i++) begin
      // Bias toward PUSH early so the stack reaches full depth.
      o = (i < 200 && $urandom_range(0, 2) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
      do_op(o, DW'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) == 0));
    end
  endtask

  initial begin
    reset = 1'b1; op = '0; din = '0; clear_err = 1'b0;
    test_reset();
    test_push_pop();
    test_overflow();
    test_swap();
    test_replace_empty();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
